// File: rtl/pacman_pkg.sv
// Shared types for the Pacman board: direction codes, input-controller
// states and the round-robin direction picker.
package pacman_pkg;

  // Direction codes, in the same bit order as the direction LEDs
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  // Direction-input controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    LOCKED = 2'd2
  } ctrl_state_e;

  localparam int NUM_DIRS = 4;

  // First set request searching upward from last+1 with wrap-around.
  // Offset 4 wraps to last itself, so the previous winner is considered
  // only after every other direction.
  function automatic logic [1:0] rr_pick(input logic [NUM_DIRS-1:0] req,
                                         input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] result;
    logic       found;
    result = last + 2'd1;
    found  = 1'b0;
    for (int k = 1; k <= NUM_DIRS; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        result = idx;
        found  = 1'b1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchronizer followed by a level debouncer that
// accepts a new level only after DEBOUNCE_CYCLES consecutive differing samples.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic stable
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync_q;
  logic [CW-1:0] cnt;

  // Two-stage synchronizer bringing the raw pin into the clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= btn_raw;
      sync_q    <= sync_meta;
    end
  end

  // Count consecutive samples that disagree with the accepted level; flip on the last one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync_q == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync_q;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dir_input_ctrl.sv
// Player-direction input path: debounces the four direction buttons,
// grants one of them round-robin, and latches game-over into a blinking
// LED override that freezes all further input until reset.
module dir_input_ctrl
  import pacman_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_CYCLES    = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic       game_over,
  output logic [1:0] dir,
  output logic       pressed,
  output logic       dir_valid,
  output logic       go_led
);

  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic [NUM_DIRS-1:0] stable;
  logic [1:0]          pick;

  ctrl_state_e         state;
  ctrl_state_e         state_n;
  logic [1:0]          dir_n;
  logic [1:0]          last_grant;
  logic [1:0]          last_grant_n;
  logic                pressed_n;
  logic                dir_valid_n;
  logic                go_led_n;
  logic [BW-1:0]       blink_cnt;
  logic [BW-1:0]       blink_cnt_n;

  for (genvar i = 0; i < NUM_DIRS; i++) begin : g_debounce
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(btn[i]),
      .stable (stable[i])
    );
  end

  assign pick = rr_pick(stable, last_grant);

  // Next-state logic: grant, hold, regrant, release, and the game-over lock with its blink
  always_comb begin
    state_n      = state;
    dir_n        = dir;
    last_grant_n = last_grant;
    pressed_n    = pressed;
    dir_valid_n  = 1'b0;
    go_led_n     = go_led;
    blink_cnt_n  = blink_cnt;

    case (state)
      IDLE: begin
        if (game_over) begin
          state_n     = LOCKED;
          pressed_n   = 1'b0;
          go_led_n    = 1'b1;
          blink_cnt_n = '0;
        end else if (|stable) begin
          state_n      = HELD;
          dir_n        = pick;
          last_grant_n = pick;
          pressed_n    = 1'b1;
          dir_valid_n  = 1'b1;
        end else begin
          pressed_n = 1'b0;
        end
      end

      HELD: begin
        if (game_over) begin
          state_n     = LOCKED;
          pressed_n   = 1'b0;
          go_led_n    = 1'b1;
          blink_cnt_n = '0;
        end else if (stable[dir]) begin
          state_n = HELD;
        end else if (|stable) begin
          dir_n        = pick;
          last_grant_n = pick;
          pressed_n    = 1'b1;
          dir_valid_n  = 1'b1;
        end else begin
          state_n   = IDLE;
          pressed_n = 1'b0;
        end
      end

      LOCKED: begin
        pressed_n = 1'b0;
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt_n = '0;
          go_led_n    = ~go_led;
        end else begin
          blink_cnt_n = blink_cnt + 1'b1;
        end
      end

      default: begin
        state_n   = IDLE;
        pressed_n = 1'b0;
      end
    endcase
  end

  // Controller registers; reset restarts the round-robin search at direction 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dir        <= DIR_UP;
      last_grant <= DIR_LEFT;
      pressed    <= 1'b0;
      dir_valid  <= 1'b0;
      go_led     <= 1'b0;
      blink_cnt  <= '0;
    end else begin
      state      <= state_n;
      dir        <= dir_n;
      last_grant <= last_grant_n;
      pressed    <= pressed_n;
      dir_valid  <= dir_valid_n;
      go_led     <= go_led_n;
      blink_cnt  <= blink_cnt_n;
    end
  end

endmodule
